nolinear_seq: RTL and testbench

- Operation sequencer placed directly upstream of the nolinear datapath.
- Accepts one DATA_NUM-element vector plus a mode over a valid/ready handshake, holds it stable on the datapath input, and drives the per-stage select/enable controls for one or two passes.
- Drives the datapath's valid (feedback-round) input and captures the final datapath output into a result register, presented over a valid/ready handshake.
- One operation in flight at a time.

---
 rtl/nolinear_pkg.sv | 52 +++++
 rtl/nolinear_seq.sv | 150 +++++++++++++++
 tb/tb_nolinear_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nolinear_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nolinear_pkg
// Brief   : Mode encodings, per-pass control words and FSM states for the
//           nolinear operation sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package nolinear_pkg;

  localparam int Bf = 8;

  localparam logic [1:0] MODE_SOFTMAX = 2'b00;
  localparam logic [1:0] MODE_GELU    = 2'b01;
  localparam logic [1:0] MODE_SILU    = 2'b10;
  localparam logic [1:0] MODE_ROOT    = 2'b11;

  typedef struct packed {
    logic [2:0] s_in;
    logic       s_mux;
    logic [2:0] s_mult;
    logic       s_add;
    logic       en_add;
    logic       en_mult;
  } ctrl_t;

  // Indexed by mode: softmax, gelu, silu, root.
  localparam ctrl_t CTRL_P1 [4] = '{
    '{3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1},
    '{3'd2, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0},
    '{3'd5, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1},
    '{3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1}
  };

  localparam ctrl_t CTRL_P2 [4] = '{
    '{3'd1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1},
    '{3'd4, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1},
    '{3'd6, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0},
    '{3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}
  };

  localparam logic [1:0] NPASS [4] = '{2'd2, 2'd2, 2'd2, 2'd1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAXWAIT = 3'd1,
    ST_PASS1   = 3'd2,
    ST_PASS2   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nolinear_seq.sv
`default_nettype none
// ============================================================================
// Module  : nolinear_seq
// Brief   : One-at-a-time operation sequencer driving the nolinear datapath
//           controls and capturing its result behind a valid/ready port.
// Revision: 1.0 - initial release
// ============================================================================
module nolinear_seq
  import nolinear_pkg::*;
#(
  parameter int FIX_POINT_WIDTH = 16,
  parameter int DATA_NUM        = 4,
  parameter int PASS_LAT        = 4,
  parameter int MAX_LAT         = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in_data,
  output logic [1:0]                          dp_mode,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_in,
  output logic                                dp_valid,
  output logic [2:0]                          dp_s_in,
  output logic                                dp_s_mux,
  output logic [2:0]                          dp_s_mult,
  output logic                                dp_s_add,
  output logic                                dp_en_add,
  output logic                                dp_en_mult,
  input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] dp_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_NUM*FIX_POINT_WIDTH-1:0] out_data,
  output logic [1:0]                          out_mode,
  output logic                                busy
);

  localparam int C_VEC_W = DATA_NUM * FIX_POINT_WIDTH;
  localparam int C_CNT_W = $clog2(((MAX_LAT > PASS_LAT) ? MAX_LAT : PASS_LAT) + 1);
  localparam logic [C_CNT_W-1:0] C_PASS_LAST = C_CNT_W'(PASS_LAT);
  localparam logic [C_CNT_W-1:0] C_MAX_LAST  = C_CNT_W'(MAX_LAT - 1);

  state_t             r_state;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_VEC_W-1:0] r_data;
  logic [1:0]         r_mode;
  ctrl_t              r_ctrl;
  logic               r_dp_valid;
  logic               r_out_valid;
  logic [C_VEC_W-1:0] r_out_data;
  logic [1:0]         r_out_mode;

  // Controls are loaded with the next state so they are right on the first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_mode      <= '0;
      r_ctrl      <= '0;
      r_dp_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mode  <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ctrl      <= '0;
      r_dp_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_mode  <= in_mode;
            r_cnt   <= '0;
            r_ctrl  <= CTRL_P1[in_mode];
            r_state <= (in_mode == MODE_SOFTMAX) ? ST_MAXWAIT : ST_PASS1;
          end
        end
        ST_MAXWAIT: begin
          if (r_cnt == C_MAX_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_PASS1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PASS1: begin
          if (r_cnt == C_PASS_LAST) begin
            r_cnt <= '0;
            if (NPASS[r_mode] == 2'd2) begin
              r_state    <= ST_PASS2;
              r_ctrl     <= CTRL_P2[r_mode];
              r_dp_valid <= 1'b1;
            end else begin
              r_state     <= ST_DONE;
              r_ctrl      <= '0;
              r_out_data  <= dp_out;
              r_out_mode  <= r_mode;
              r_out_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PASS2: begin
          if (r_cnt == C_PASS_LAST) begin
            r_cnt       <= '0;
            r_state     <= ST_DONE;
            r_ctrl      <= '0;
            r_dp_valid  <= 1'b0;
            r_out_data  <= dp_out;
            r_out_mode  <= r_mode;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign dp_in      = r_data;
  assign dp_mode    = r_mode;
  assign dp_valid   = r_dp_valid;
  assign dp_s_in    = r_ctrl.s_in;
  assign dp_s_mux   = r_ctrl.s_mux;
  assign dp_s_mult  = r_ctrl.s_mult;
  assign dp_s_add   = r_ctrl.s_add;
  assign dp_en_add  = r_ctrl.en_add;
  assign dp_en_mult = r_ctrl.en_mult;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_mode   = r_out_mode;

endmodule
`default_nettype wire

// File: tb/tb_nolinear_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_nolinear_seq
// Brief   : Scoreboard bench for nolinear_seq with a 4-stage datapath stub.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nolinear_seq;

  localparam int VW       = 64;
  localparam int PASS_LAT = 4;
  localparam int MAX_LAT  = 4;
  localparam int CYC      = PASS_LAT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [1:0]    in_mode = 2'b00;
  logic [VW-1:0] in_data = '0;
  logic          in_ready, dp_valid, dp_s_mux, dp_s_add, dp_en_add, dp_en_mult;
  logic          out_valid, busy;
  logic [2:0]    dp_s_in, dp_s_mult;
  logic [1:0]    dp_mode, out_mode;
  logic [VW-1:0] dp_in, dp_out, out_data;
  logic [VW-1:0] stub [4];

  nolinear_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .dp_mode(dp_mode), .dp_in(dp_in),
    .dp_valid(dp_valid), .dp_s_in(dp_s_in), .dp_s_mux(dp_s_mux), .dp_s_mult(dp_s_mult),
    .dp_s_add(dp_s_add), .dp_en_add(dp_en_add), .dp_en_mult(dp_en_mult), .dp_out(dp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: 4 register stages; feedback rounds invert every bit.
  always @(posedge clk) begin
    stub[0] <= dp_in ^ {VW{dp_valid}};
    for (int i = 1; i < 4; i++) stub[i] <= stub[i-1];
  end
  assign dp_out = stub[3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] p1w(input logic [1:0] m);
    case (m)
      2'd0:    return 10'b000_0_001_0_0_1;
      2'd1:    return 10'b010_1_011_0_1_0;
      2'd2:    return 10'b101_1_101_0_0_1;
      default: return 10'b011_1_000_0_1_1;
    endcase
  endfunction

  function automatic logic [9:0] p2w(input logic [1:0] m);
    case (m)
      2'd0:    return 10'b001_0_010_1_1_1;
      2'd1:    return 10'b100_0_100_1_1_1;
      2'd2:    return 10'b110_0_110_1_1_0;
      default: return 10'b000_0_000_0_0_0;
    endcase
  endfunction

  typedef struct {
    logic [VW-1:0] res;
    logic [1:0]    mode;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            n_pass = 0;
  int            n_tot  = 0;
  int            n_to   = 0;
  logic [VW-1:0] m_dp_in = '0;
  logic [1:0]    m_dp_mode = 2'b00;
  logic [VW-1:0] m_out_data = '0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
  endtask

  // Monitor: reference timeline derived from the oldest outstanding request.
  initial begin : monitor
    logic [9:0] e_ctrl;
    logic       e_dv, e_ov, e_inr, e_busy, e_done, c_ctrl, two;
    int         d, pre, lat1;
    exp_t       e;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (!rst) begin
        chk("reset_flags", 128'({in_ready, busy, out_valid, dp_valid, dp_mode, out_mode}),
            128'({4'b1000, 2'b00, 2'b00}));
        chk("reset_ctrl", 128'({dp_s_in, dp_s_mux, dp_s_mult, dp_s_add, dp_en_add, dp_en_mult}),
            128'(0));
        chk("reset_data", {dp_in, out_data}, 128'(0));
        q.delete();
        m_dp_in    = '0;
        m_dp_mode  = 2'b00;
        m_out_data = '0;
      end else begin
        e_ctrl = '0; e_dv = 1'b0; e_ov = 1'b0; e_inr = 1'b1; e_busy = 1'b0;
        e_done = 1'b0; c_ctrl = 1'b1; d = 0; lat1 = 0;
        if (q.size() != 0) begin
          d    = cyc - q[0].acc;
          pre  = (q[0].mode == 2'd0) ? MAX_LAT : 0;
          two  = (q[0].mode != 2'd3);
          lat1 = pre + (two ? 2 : 1) * CYC;
          e_inr = 1'b0; e_busy = 1'b1;
          if (d < pre + CYC) e_ctrl = p1w(q[0].mode);
          else if (d < lat1) begin e_ctrl = p2w(q[0].mode); e_dv = 1'b1; end
          else begin e_done = 1'b1; e_ov = 1'b1; c_ctrl = 1'b0; end
        end
        chk("flags", 128'({in_ready, busy, out_valid, dp_valid}), 128'({e_inr, e_busy, e_ov, e_dv}));
        if (c_ctrl)
          chk("ctrl", 128'({dp_s_in, dp_s_mux, dp_s_mult, dp_s_add, dp_en_add, dp_en_mult}),
              128'(e_ctrl));
        chk("dp_hold", 128'({dp_mode, dp_in}), 128'({m_dp_mode, m_dp_in}));
        chk("out_data", 128'(out_data), 128'(m_out_data));
        if (e_done) chk("out_mode", 128'(out_mode), 128'(q[0].mode));

        // What the coming edge does.
        if (flush) begin
          q.delete();
        end else if (q.size() == 0) begin
          if (in_valid) begin
            e.res  = (in_mode == 2'd3) ? in_data : ~in_data;
            e.mode = in_mode;
            e.acc  = cyc + 1;
            q.push_back(e);
            m_dp_in   = in_data;
            m_dp_mode = in_mode;
          end
        end else if (d == lat1 - 1) begin
          m_out_data = q[0].res;
        end else if (d >= lat1 && out_ready) begin
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [VW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send(input logic [1:0] m, input logic [VW-1:0] dat);
    in_valid = 1'b1; in_mode = m; in_data = dat;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd64();
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_to++;
    $display("FAIL send_timeout got=no_accept expected=accept");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    n_to++;
    $display("FAIL idle_timeout got=pending expected=empty");
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send(2'b11, 64'h0400_0200_0100_0080);
    wait_idle();
    send(2'b00, rnd64());
    wait_idle();

    // Gelu held in DONE for 7 cycles with stray in_valid pulses.
    out_ready = 1'b0;
    send(2'b01, rnd64());
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0]; in_mode = 2'($urandom); in_data = rnd64();
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();

    // Silu flushed at PASS2 count 2, then flush racing a request in IDLE.
    send(2'b10, rnd64());
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = 2'b01; in_data = rnd64();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    send(2'b11, rnd64());
    wait_idle();

    // Asynchronous reset pulse in the middle of PASS1.
    send(2'b01, rnd64());
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #3 rst = 1'b1;
    @(negedge clk);
    send(2'b01, rnd64());
    wait_idle();

    // Back-to-back: in_valid held high.
    in_valid = 1'b1; in_mode = 2'b01; in_data = rnd64();
    for (int i = 0; i < 30; i++) begin @(negedge clk); in_data = rnd64(); end
    for (int i = 0; i < 20 && in_ready; i++) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    for (int k = 0; k < 20; k++) begin
      send(2'($urandom_range(0, 3)), rnd64());
      for (int i = 0; i < 100 && q.size() != 0; i++) begin
        out_ready = ($urandom_range(0, 1) == 1);
        in_valid  = !in_ready && ($urandom_range(0, 1) == 1);
        in_mode   = 2'($urandom);
        in_data   = rnd64();
        @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot + n_to);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
